serial_subtractor: RTL and testbench

Bit-serial subtractor computing a − b one bit per clock, LSB first, built around a full-subtractor cell (difference/borrow, the inverse of the adder's sum/carry) with a registered borrow. It sits alongside the arithmetic primitives as the area-cheap sequential counterpart for multi-bit subtraction. A start/busy/done handshake controls it, and it holds its result until the next operation completes.

---
 rtl/serial_subtractor.sv | 173 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one full-subtractor cell
// with a registered borrow. start/busy/done handshake; the result is held
// until the next operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] fsub(input logic ai, input logic bi, input logic bri);
    logic d_v;
    logic bo_v;
    d_v  = ai ^ bi ^ bri;
    bo_v = (~ai & bi) | (~(ai ^ bi) & bri);
    return {bo_v, d_v};
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_sh_r;
  logic             br_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             busy_r;
  logic             done_r;
  logic             busy_s;
  logic             done_s;
  logic [1:0]       cell_s;
  logic             last_s;

  assign cell_s = fsub(a_sh_r[0], b_sh_r[0], br_r);
  assign last_s = (cnt_r == CNT_LAST);

  // State register; reset wins over everything, including a coincident start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: start is only looked at in IDLE, never queued.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so busy/done can be registered
  // and still line up with the state they describe.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_nxt_s)
      ST_IDLE: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      ST_RUN: begin
        busy_s = 1'b1;
        done_s = 1'b0;
      end
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Handshake output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Datapath: operand capture, one bit per RUN cycle, result load on the
  // edge that enters DONE (the final bit is folded in directly there).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= CNT_ZERO;
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      res_sh_r <= {WIDTH{1'b0}};
      br_r     <= 1'b0;
      diff_r   <= {WIDTH{1'b0}};
      borrow_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_sh_r <= a;
            b_sh_r <= b;
            br_r   <= 1'b0;
            cnt_r  <= CNT_ZERO;
          end else begin
            br_r   <= br_r;
          end
        end
        ST_RUN: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          res_sh_r <= {cell_s[0], res_sh_r[WIDTH-1:1]};
          br_r     <= cell_s[1];
          cnt_r    <= cnt_r + CNT_ONE;
          if (last_s) begin
            diff_r   <= {cell_s[0], res_sh_r[WIDTH-1:1]};
            borrow_r <= cell_s[1];
          end else begin
            borrow_r <= borrow_r;
          end
        end
        default: begin
          br_r <= br_r;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign diff   = diff_r;
  assign borrow = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed table,
// handshake/timing corner sequences and random operands vs. an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int n_checks;
  int n_fail;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] ed;
    logic         eb;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic, modulo 2^W, borrow when a < b.
  function automatic logic [W:0] model_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned d;
    d = (int'(x) - int'(y) + (1 << W)) % (1 << W);
    return {(x < y), d[W-1:0]};
  endfunction

  // One full operation with timing checks. scramble changes the operand
  // inputs every RUN cycle; pulse raises start mid-RUN with other operands.
  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb,
                        input bit scramble, input bit pulse);
    logic [W-1:0] prev_d;
    logic         prev_b;
    int           cyc;
    int           bcnt;
    bit           got;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    prev_d = diff; prev_b = borrow;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; bcnt = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (cyc == 1) begin
        chk({name, "_hold_diff"}, 32'(diff), 32'(prev_d));
        chk({name, "_hold_borrow"}, 32'(borrow), 32'(prev_b));
      end
      if (done) begin
        got = 1'b1;
      end else begin
        if (scramble) begin
          a = W'($urandom); b = W'($urandom);
        end
        if (pulse && cyc == 3) begin
          start = 1'b1; a = 8'h55; b = 8'h11;
        end else begin
          start = 1'b0;
        end
      end
    end
    chk({name, "_done_seen"}, 32'(got), 32'd1);
    chk({name, "_latency"}, 32'(cyc), 32'(W + 1));
    chk({name, "_busy_cycles"}, 32'(bcnt), 32'(W + 1));
    chk({name, "_diff"}, 32'(diff), 32'(ed));
    chk({name, "_borrow"}, 32'(borrow), 32'(eb));
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({name, "_diff_held"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    vec_t  vecs[6];
    logic [W:0] m;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int    last_done;
    int    pulses;
    int    dcnt;
    bit    prev_done;

    n_checks = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h7F, 8'h01, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].eb, 1'b0, 1'b0);
    end

    // start held high: one result every W+2 cycles, single-cycle done pulses.
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    last_done = -1; pulses = 0; prev_done = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        chk("held_diff", 32'(diff), 32'h0F);
        chk("held_borrow", 32'(borrow), 32'd0);
        chk("held_single", 32'(prev_done), 32'd0);
        if (last_done >= 0) chk("held_period", 32'(c - last_done), 32'(W + 2));
        else chk("held_first", 32'(c), 32'(W + 1));
        last_done = c;
      end
      prev_done = done;
    end
    chk("held_pulses", 32'(pulses), 32'd4);
    start = 1'b0;
    dcnt = 0;
    while (busy && dcnt < 15) begin
      @(negedge clk);
      dcnt++;
    end
    chk("held_drain", 32'(busy), 32'd0);

    // start pulsed mid-RUN with other operands is ignored.
    run_op("midpulse", 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b1);

    // Reset in RUN aborts without a done pulse.
    @(negedge clk);
    a = 8'h20; b = 8'h01; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    run_op("after_abort", 8'h09, 8'h0A, 8'hFF, 1'b1, 1'b0, 1'b0);

    // start coincident with rst is dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 8'h33; b = 8'h11;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rst_start_idle", 32'(busy), 32'd0);

    // Operands changing during RUN do not disturb the captured values.
    m = model_sub(8'hC4, 8'h3B);
    run_op("scramble", 8'hC4, 8'h3B, m[W-1:0], m[W], 1'b1, 1'b0);

    // Random operands against the arithmetic model.
    for (int k = 0; k < 20; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (k == 0) begin ra = 8'h00; rb = 8'hFF; end
      m = model_sub(ra, rb);
      run_op($sformatf("rnd%0d", k), ra, rb, m[W-1:0], m[W], (k % 3) == 1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
